abc_vector_sequencer: RTL and testbench

//   Upstream stimulus/check stage for the 3-input combinational circuit (X = A | (~B & ~C)).
//   On start, drives all 8 {A,B,C} vectors in ascending order, holding each for HOLD_CYCLES.

---
 rtl/abc_vector_sequencer_pkg.sv | 14 +
 rtl/abc_vector_sequencer.sv | 107 ++++++++++
 tb/tb_abc_vector_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/abc_vector_sequencer_pkg.sv
// rtl/abc_vector_sequencer_pkg.sv - shared state encoding and constants for the ABC vector sequencer
package abc_vector_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_FINISH = 2'd2
    } seq_state_t;

    localparam logic [7:0] DEFAULT_TRUTH = 8'hF1;
    localparam int         NUM_VEC       = 8;
    localparam logic [2:0] LAST_VEC      = 3'(NUM_VEC - 1);

endpackage

// File: rtl/abc_vector_sequencer.sv
// rtl/abc_vector_sequencer.sv - sweeps all {a,b,c} vectors and checks x_in against a golden truth table
module abc_vector_sequencer
    import abc_vector_sequencer_pkg::*;
#(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [7:0] TRUTH       = DEFAULT_TRUTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x_in,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       mismatch,
    output logic [3:0] err_cnt,
    output logic       done,
    output logic       pass
);

    seq_state_t state;
    seq_state_t next_state;
    logic [3:0] hold_cnt;
    logic       accept;
    logic       sample;

    // a/b/c are the bits of the registered vector index, so {a,b,c}==vec_idx always
    assign a = vec_idx[2];
    assign b = vec_idx[1];
    assign c = vec_idx[0];

    assign accept = (state == ST_IDLE) && start;
    assign sample = (state == ST_DRIVE) && (hold_cnt == 4'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (sample && (vec_idx == LAST_VEC)) begin
                    next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_idx  <= 3'd0;
            hold_cnt <= 4'd0;
            busy     <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= 4'd0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            done     <= 1'b0;
            if (accept) begin
                vec_idx  <= 3'd0;
                hold_cnt <= 4'd0;
                err_cnt  <= 4'd0;
                pass     <= 1'b0;
                busy     <= 1'b1;
            end else if (state == ST_DRIVE) begin
                if (sample) begin
                    if (x_in != TRUTH[vec_idx]) begin
                        err_cnt  <= err_cnt + 4'd1;
                        mismatch <= 1'b1;
                    end
                    hold_cnt <= 4'd0;
                    // The last vector stays on the outputs after the sweep
                    if (vec_idx != LAST_VEC) begin
                        vec_idx <= vec_idx + 3'd1;
                    end
                end else begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
            end else if (state == ST_FINISH) begin
                done <= 1'b1;
                busy <= 1'b0;
                pass <= (err_cnt == 4'd0);
            end
        end
    end

endmodule

// File: tb/tb_abc_vector_sequencer.sv
// tb/tb_abc_vector_sequencer.sv - self-checking bench for abc_vector_sequencer
module tb_abc_vector_sequencer;

    localparam logic [7:0] TRUTH_REF = 8'hF1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic use1;
    logic rnd_x;
    int   mode;
    int   checks = 0;
    int   errors = 0;
    int   mm_seen;

    logic       start0, a0, b0, c0, x0, busy0, mm0, done0, pass0;
    logic [2:0] vec0;
    logic [3:0] err0;
    logic       start1, a1, b1, c1, x1, busy1, mm1, done1, pass1;
    logic [2:0] vec1;
    logic [3:0] err1;

    logic       o_a, o_b, o_c, o_busy, o_mm, o_done, o_pass;
    logic [2:0] o_vec;
    logic [3:0] o_err;

    always #5 clk = ~clk;

    function automatic logic circ(input logic ia, input logic ib, input logic ic);
        return ia | (~ib & ~ic);
    endfunction

    function automatic logic drive_x(input int m, input logic ia, input logic ib,
                                     input logic ic, input logic r);
        case (m)
            0:       return circ(ia, ib, ic);
            1:       return 1'b0;
            2:       return ~circ(ia, ib, ic);
            default: return r;
        endcase
    endfunction

    assign start0 = use1 ? 1'b0 : start;
    assign start1 = use1 ? start : 1'b0;
    assign x0 = drive_x(mode, a0, b0, c0, rnd_x);
    assign x1 = drive_x(mode, a1, b1, c1, rnd_x);

    abc_vector_sequencer #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .c(c0), .x_in(x0),
        .vec_idx(vec0), .busy(busy0), .mismatch(mm0), .err_cnt(err0), .done(done0), .pass(pass0)
    );

    abc_vector_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .x_in(x1),
        .vec_idx(vec1), .busy(busy1), .mismatch(mm1), .err_cnt(err1), .done(done1), .pass(pass1)
    );

    always_comb begin
        o_a    = use1 ? a1    : a0;
        o_b    = use1 ? b1    : b0;
        o_c    = use1 ? c1    : c0;
        o_vec  = use1 ? vec1  : vec0;
        o_busy = use1 ? busy1 : busy0;
        o_mm   = use1 ? mm1   : mm0;
        o_err  = use1 ? err1  : err0;
        o_done = use1 ? done1 : done0;
        o_pass = use1 ? pass1 : pass0;
    end

    // One sweep from an idle negedge; starts re-pulsed at sweep cycles i0..i3 must be ignored.
    task automatic run_sweep(input int m, input int h, input int i0, input int i1,
                             input int i2, input int i3);
        int         exp_err;
        logic       mm_pend;
        logic       pend;
        logic       xv;
        logic [2:0] ve;
        logic [14:0] got, exp;
        exp_err = 0;
        mm_pend = 1'b0;
        mm_seen = 0;
        mode    = m;
        start   = 1'b1;
        for (int j = 1; j <= 8 * h + 3; j++) begin
            @(negedge clk);
            ve  = (j <= 8 * h) ? 3'((j - 1) / h) : 3'd7;
            got = {o_busy, o_done, o_mm, o_pass, o_err, o_vec, o_a, o_b, o_c};
            exp = {logic'(j <= 8 * h + 1), logic'(j == 8 * h + 2), mm_pend,
                   logic'(j >= 8 * h + 2 && exp_err == 0), 4'(exp_err), ve, ve};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sweep_cycle mode=%0d h=%0d j=%0d {busy,done,mm,pass,err,vec,abc} got %h exp %h",
                         m, h, j, got, exp);
            end
            if (o_mm === 1'b1) mm_seen++;
            rnd_x = 1'($urandom_range(0, 1));
            start = (j == i0 || j == i1 || j == i2 || j == i3);
            case (m)
                0:       xv = circ(ve[2], ve[1], ve[0]);
                1:       xv = 1'b0;
                2:       xv = ~circ(ve[2], ve[1], ve[0]);
                default: xv = rnd_x;
            endcase
            pend = 1'b0;
            if (j <= 8 * h && ((j - 1) % h) == h - 1) begin
                pend = (xv != TRUTH_REF[ve]);
                if (pend) exp_err++;
            end
            mm_pend = pend;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        use1  = 1'b0;
        mode  = 0;
        rnd_x = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a0, b0, c0, vec0, busy0, mm0, err0, done0, pass0, a1, vec1, busy1, err1, done1, pass1} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%0b err=%0d vec=%0d pass=%0b exp all zero",
                     busy0, err0, vec0, pass0);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_circuit();
        run_sweep(0, 4, -1, -1, -1, -1);
        checks++;
        if (o_err !== 4'd0 || o_pass !== 1'b1 || mm_seen != 0) begin
            errors++;
            $display("FAIL circuit got err=%0d pass=%0b pulses=%0d exp 0 1 0", o_err, o_pass, mm_seen);
        end
    endtask

    task automatic test_const_zero();
        run_sweep(1, 4, -1, -1, -1, -1);
        checks++;
        if (o_err !== 4'd5 || o_pass !== 1'b0 || mm_seen != 5) begin
            errors++;
            $display("FAIL const_zero got err=%0d pass=%0b pulses=%0d exp 5 0 5", o_err, o_pass, mm_seen);
        end
    endtask

    task automatic test_inverted();
        run_sweep(2, 4, -1, -1, -1, -1);
        checks++;
        if (o_err !== 4'd8 || o_pass !== 1'b0 || mm_seen != 8) begin
            errors++;
            $display("FAIL inverted got err=%0d pass=%0b pulses=%0d exp 8 0 8", o_err, o_pass, mm_seen);
        end
    endtask

    task automatic test_back_to_back();
        // Restart attempts mid-sweep, on the final sample cycle and during FINISH
        run_sweep(0, 4, 3, 20, 32, 33);
        checks++;
        if (o_err !== 4'd0 || o_pass !== 1'b1) begin
            errors++;
            $display("FAIL ignored_start got err=%0d pass=%0b exp 0 1", o_err, o_pass);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) run_sweep(3, 4, -1, -1, -1, -1);
    endtask

    task automatic test_async_reset();
        int done_seen;
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * 4 + 1) @(negedge clk);
        checks++;
        if (o_vec !== 3'd3 || o_err !== 4'd1) begin
            errors++;
            $display("FAIL pre_reset got vec=%0d err=%0d exp 3 1", o_vec, o_err);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_a, o_b, o_c, o_vec, o_busy, o_mm, o_err, o_done, o_pass} !== '0) begin
            errors++;
            $display("FAIL async_reset got vec=%0d busy=%0b err=%0d exp all zero", o_vec, o_busy, o_err);
        end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL post_reset_quiet got %0d active cycles exp 0", done_seen);
        end
        run_sweep(0, 4, -1, -1, -1, -1);
        checks++;
        if (o_pass !== 1'b1) begin
            errors++;
            $display("FAIL fresh_start got pass=%0b exp 1", o_pass);
        end
    endtask

    task automatic test_hold_one();
        use1 = 1'b1;
        @(negedge clk);
        run_sweep(0, 1, -1, -1, -1, -1);
        checks++;
        if (o_err !== 4'd0 || o_pass !== 1'b1) begin
            errors++;
            $display("FAIL hold_one got err=%0d pass=%0b exp 0 1", o_err, o_pass);
        end
        run_sweep(1, 1, 2, 8, 9, -1);
        run_sweep(3, 1, -1, -1, -1, -1);
        use1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_circuit();
        test_const_zero();
        test_inverted();
        test_back_to_back();
        test_random();
        test_async_reset();
        test_hold_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
